// File: rtl/fence_flush_ctrl_pkg.sv
// Shared types and constants for the fence/flush controller and its channel tracker.
// No logic; sizing helpers only.
package fence_flush_ctrl_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } flush_state_e;

  localparam int unsigned DEFAULT_NR_CACHE_CH = 2;

  // The watchdog counter must hold TIMEOUT_CYCLES; a disabled watchdog still needs 1 bit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit > 0) ? $clog2(limit + 1) : 1;
  endfunction

endpackage

// File: rtl/fence_flush_ctrl_if.sv
// Commit/CSR-side causes in, pipeline flushes and per-channel cache flush handshake out.
// master drives the causes and acks; slave is the controller.
interface fence_flush_ctrl_if #(
  parameter int unsigned NR_CACHE_CH = 2
);
  logic                   mispredict_i;
  logic                   fence_i;
  logic                   fence_i_i;
  logic                   sfence_vma_i;
  logic                   flush_csr_i;
  logic                   flush_commit_i;
  logic                   ex_valid_i;
  logic                   eret_i;
  logic                   set_debug_pc_i;
  logic                   halt_csr_i;
  logic [NR_CACHE_CH-1:0] flush_cache_ack_i;

  logic                   set_pc_commit_o;
  logic                   flush_if_o;
  logic                   flush_unissued_instr_o;
  logic                   flush_id_o;
  logic                   flush_ex_o;
  logic                   flush_bp_o;
  logic                   flush_icache_o;
  logic                   flush_tlb_o;
  logic [NR_CACHE_CH-1:0] flush_cache_req_o;
  logic                   flush_timeout_o;
  logic                   busy_o;
  logic                   halt_o;

  modport master (
    output mispredict_i, fence_i, fence_i_i, sfence_vma_i, flush_csr_i, flush_commit_i,
           ex_valid_i, eret_i, set_debug_pc_i, halt_csr_i, flush_cache_ack_i,
    input  set_pc_commit_o, flush_if_o, flush_unissued_instr_o, flush_id_o, flush_ex_o,
           flush_bp_o, flush_icache_o, flush_tlb_o, flush_cache_req_o, flush_timeout_o,
           busy_o, halt_o
  );

  modport slave (
    input  mispredict_i, fence_i, fence_i_i, sfence_vma_i, flush_csr_i, flush_commit_i,
           ex_valid_i, eret_i, set_debug_pc_i, halt_csr_i, flush_cache_ack_i,
    output set_pc_commit_o, flush_if_o, flush_unissued_instr_o, flush_id_o, flush_ex_o,
           flush_bp_o, flush_icache_o, flush_tlb_o, flush_cache_req_o, flush_timeout_o,
           busy_o, halt_o
  );
endinterface

// File: rtl/fence_flush_ctrl_chan_tracker.sv
// Outstanding cache-flush channel vector with ack clearing and watchdog counter.
// Requests are the registered pending bits; a channel is released only by its own ack or the watchdog.
module fence_flush_ctrl_chan_tracker
  import fence_flush_ctrl_pkg::*;
#(
  parameter int unsigned            NR_CACHE_CH    = DEFAULT_NR_CACHE_CH,
  parameter logic [NR_CACHE_CH-1:0] FLUSH_MASK     = '1,
  parameter int unsigned            TIMEOUT_CYCLES = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start,
  input  logic                   flushing,
  input  logic [NR_CACHE_CH-1:0] ack,
  output logic [NR_CACHE_CH-1:0] pending,
  output logic                   done,
  output logic                   timeout_hit
);

  localparam int unsigned    CW       = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [NR_CACHE_CH-1:0] pending_q, pending_d, remaining;
  logic [CW-1:0]          cnt_q, cnt_d;

  assign remaining   = pending_q & ~ack;
  assign done        = flushing && (remaining == '0);
  // A final ack landing in the last watchdog cycle counts as completion, not timeout.
  assign timeout_hit = (TIMEOUT_CYCLES > 0) && flushing && !done && (cnt_q == CNT_LAST);
  assign pending     = pending_q;

  always_comb begin
    pending_d = pending_q;
    cnt_d     = cnt_q;
    if (start) begin
      pending_d = FLUSH_MASK;
      cnt_d     = '0;
    end else if (flushing) begin
      pending_d = timeout_hit ? '0 : remaining;
      if (TIMEOUT_CYCLES > 0) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: rtl/fence_flush_ctrl.sv
// Pipeline flush / PC-select generation plus fence-driven write-back cache flush sequencing.
// Stage flushes are same-cycle; cache requests and halt follow the fence by one cycle and hold until acked or timed out.
module fence_flush_ctrl
  import fence_flush_ctrl_pkg::*;
#(
  parameter int unsigned            NR_CACHE_CH    = DEFAULT_NR_CACHE_CH,
  parameter logic [NR_CACHE_CH-1:0] FLUSH_MASK     = '1,
  parameter int unsigned            TIMEOUT_CYCLES = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  fence_flush_ctrl_if.slave ctrl
);

  flush_state_e           state_q, state_d;
  logic                   timeout_q, timeout_d;
  logic                   start, done, timeout_hit;
  logic                   commit_cause, trap_cause;
  logic [NR_CACHE_CH-1:0] pending;

  // A fence seen while already flushing is not re-armed.
  assign start = (state_q == IDLE) && (ctrl.fence_i || ctrl.fence_i_i) && (FLUSH_MASK != '0);

  fence_flush_ctrl_chan_tracker #(
    .NR_CACHE_CH    (NR_CACHE_CH),
    .FLUSH_MASK     (FLUSH_MASK),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_tracker (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start       (start),
    .flushing    (state_q == FLUSH),
    .ack         (ctrl.flush_cache_ack_i),
    .pending     (pending),
    .done        (done),
    .timeout_hit (timeout_hit)
  );

  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = FLUSH;
          timeout_d = 1'b0;
        end
      end
      FLUSH: begin
        if (done) begin
          state_d = IDLE;
        end else if (timeout_hit) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
    end
  end

  assign commit_cause = ctrl.fence_i | ctrl.fence_i_i | ctrl.sfence_vma_i |
                        ctrl.flush_csr_i | ctrl.flush_commit_i;
  assign trap_cause   = ctrl.ex_valid_i | ctrl.eret_i | ctrl.set_debug_pc_i;

  // Traps take the PC from the CSR file, so they override the commit PC+4 select.
  always_comb begin
    ctrl.set_pc_commit_o        = commit_cause & ~trap_cause;
    ctrl.flush_if_o             = ctrl.mispredict_i | commit_cause | trap_cause;
    ctrl.flush_unissued_instr_o = ctrl.mispredict_i | commit_cause | trap_cause;
    ctrl.flush_id_o             = commit_cause | trap_cause;
    ctrl.flush_ex_o             = commit_cause | trap_cause;
    ctrl.flush_bp_o             = trap_cause;
    ctrl.flush_icache_o         = ctrl.fence_i_i;
    ctrl.flush_tlb_o            = ctrl.sfence_vma_i;
  end

  assign ctrl.flush_cache_req_o = pending;
  assign ctrl.flush_timeout_o   = timeout_q;
  assign ctrl.busy_o            = (state_q == FLUSH);
  assign ctrl.halt_o            = ctrl.halt_csr_i | (state_q == FLUSH);

endmodule

// File: tb/tb_fence_flush_ctrl.sv
// Two controllers (mask 11 with 8-cycle watchdog; mask 10 without) share one stimulus stream
// and are checked against an event-level model of the flush sequence.
module tb_fence_flush_ctrl;

  localparam logic [1:0] D0_MASK = 2'b11;
  localparam int         D0_TO   = 8;
  localparam logic [1:0] D1_MASK = 2'b10;
  localparam int         D1_TO   = 0;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       mis, fen, fii, sfv, csr, cmt, exv, ert, dbg, hlt;
  logic [1:0] ack;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: per instance, whether a flush is in progress, which channels still owe an ack,
  // how many flush cycles have elapsed, and whether the last flush was abandoned.
  bit         m_busy [2];
  logic [1:0] m_pend [2];
  int         m_cnt  [2];
  bit         m_to   [2];

  always #5 clk_i = ~clk_i;

  fence_flush_ctrl_if #(.NR_CACHE_CH(2)) if0 ();
  fence_flush_ctrl_if #(.NR_CACHE_CH(2)) if1 ();

  assign if0.mispredict_i = mis;   assign if1.mispredict_i = mis;
  assign if0.fence_i = fen;        assign if1.fence_i = fen;
  assign if0.fence_i_i = fii;      assign if1.fence_i_i = fii;
  assign if0.sfence_vma_i = sfv;   assign if1.sfence_vma_i = sfv;
  assign if0.flush_csr_i = csr;    assign if1.flush_csr_i = csr;
  assign if0.flush_commit_i = cmt; assign if1.flush_commit_i = cmt;
  assign if0.ex_valid_i = exv;     assign if1.ex_valid_i = exv;
  assign if0.eret_i = ert;         assign if1.eret_i = ert;
  assign if0.set_debug_pc_i = dbg; assign if1.set_debug_pc_i = dbg;
  assign if0.halt_csr_i = hlt;     assign if1.halt_csr_i = hlt;
  assign if0.flush_cache_ack_i = ack;
  assign if1.flush_cache_ack_i = ack;

  fence_flush_ctrl #(.NR_CACHE_CH(2), .FLUSH_MASK(D0_MASK), .TIMEOUT_CYCLES(D0_TO)) dut0 (
    .clk_i (clk_i), .rst_ni (rst_ni), .ctrl (if0)
  );
  fence_flush_ctrl #(.NR_CACHE_CH(2), .FLUSH_MASK(D1_MASK), .TIMEOUT_CYCLES(D1_TO)) dut1 (
    .clk_i (clk_i), .rst_ni (rst_ni), .ctrl (if1)
  );

  // {set_pc, if, unissued, id, ex, bp, icache, tlb, req[1:0], timeout, busy, halt}
  wire [12:0] act0 = {if0.set_pc_commit_o, if0.flush_if_o, if0.flush_unissued_instr_o,
                      if0.flush_id_o, if0.flush_ex_o, if0.flush_bp_o, if0.flush_icache_o,
                      if0.flush_tlb_o, if0.flush_cache_req_o, if0.flush_timeout_o,
                      if0.busy_o, if0.halt_o};
  wire [12:0] act1 = {if1.set_pc_commit_o, if1.flush_if_o, if1.flush_unissued_instr_o,
                      if1.flush_id_o, if1.flush_ex_o, if1.flush_bp_o, if1.flush_icache_o,
                      if1.flush_tlb_o, if1.flush_cache_req_o, if1.flush_timeout_o,
                      if1.busy_o, if1.halt_o};

  function automatic logic [1:0] mask_of(input int k);
    return (k == 0) ? D0_MASK : D1_MASK;
  endfunction

  function automatic int to_of(input int k);
    return (k == 0) ? D0_TO : D1_TO;
  endfunction

  function automatic logic [12:0] exp_vec(input int k);
    logic trap, cmtc;
    trap = exv | ert | dbg;
    cmtc = fen | fii | sfv | csr | cmt;
    return {cmtc & ~trap, mis | cmtc | trap, mis | cmtc | trap, cmtc | trap, cmtc | trap,
            trap, fii, sfv, m_pend[k], m_to[k], m_busy[k], hlt | m_busy[k]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0; m_pend[k] = 2'b00; m_cnt[k] = 0; m_to[k] = 0;
    end
  endtask

  task automatic model_step();
    logic [1:0] rem;
    for (int k = 0; k < 2; k++) begin
      if (!m_busy[k]) begin
        if ((fen | fii) && mask_of(k) != 2'b00) begin
          m_busy[k] = 1; m_pend[k] = mask_of(k); m_cnt[k] = 0; m_to[k] = 0;
        end
      end else begin
        rem = m_pend[k] & ~ack;
        m_cnt[k]++;
        if (rem == 2'b00) begin
          m_busy[k] = 0; m_pend[k] = 2'b00;
        end else if (to_of(k) != 0 && m_cnt[k] == to_of(k)) begin
          m_busy[k] = 0; m_pend[k] = 2'b00; m_to[k] = 1;
        end else begin
          m_pend[k] = rem;
        end
      end
    end
  endtask

  task automatic clr_in();
    {mis, fen, fii, sfv, csr, cmt, exv, ert, dbg, hlt} = '0;
    ack = 2'b00;
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      model_step();
      @(negedge clk_i);
    end
  endtask

  task automatic test_reset();
    clr_in();
    rst_ni = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_i);
    #1;
    n_checks++;
    if (act0 !== 13'h0) begin n_fail++; $display("FAIL reset_dut0: got %h want 0000", act0); end
    n_checks++;
    if (act1 !== 13'h0) begin n_fail++; $display("FAIL reset_dut1: got %h want 0000", act1); end
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_fence_seq();
    clr_in(); fen = 1'b1; #1;
    n_checks++;
    if (if0.flush_if_o !== 1'b1 || if0.set_pc_commit_o !== 1'b1 || if0.flush_cache_req_o !== 2'b00) begin
      n_fail++; $display("FAIL fence_c0: if=%b pc=%b req=%b want 1 1 00",
                         if0.flush_if_o, if0.set_pc_commit_o, if0.flush_cache_req_o);
    end
    tick(); fen = 1'b0; #1;
    n_checks++;
    if (if0.flush_cache_req_o !== 2'b11 || if0.halt_o !== 1'b1) begin
      n_fail++; $display("FAIL fence_c1: req=%b halt=%b want 11 1", if0.flush_cache_req_o, if0.halt_o);
    end
    tick(2); ack = 2'b10;
    tick(); ack = 2'b00; #1;
    n_checks++;
    if (if0.flush_cache_req_o !== 2'b01 || if0.halt_o !== 1'b1) begin
      n_fail++; $display("FAIL fence_c4: req=%b halt=%b want 01 1", if0.flush_cache_req_o, if0.halt_o);
    end
    tick(); ack = 2'b01;
    tick(); ack = 2'b00; #1;
    n_checks++;
    if (if0.flush_cache_req_o !== 2'b00 || if0.halt_o !== 1'b0 || if0.busy_o !== 1'b0) begin
      n_fail++; $display("FAIL fence_c6: req=%b halt=%b busy=%b want 00 0 0",
                         if0.flush_cache_req_o, if0.halt_o, if0.busy_o);
    end
  endtask

  task automatic test_partial_mask();
    clr_in(); fii = 1'b1; #1;
    n_checks++;
    if (if1.flush_icache_o !== 1'b1) begin
      n_fail++; $display("FAIL mask_icache: got %b want 1", if1.flush_icache_o);
    end
    tick(); fii = 1'b0; #1;
    n_checks++;
    if (if1.flush_cache_req_o !== 2'b10) begin
      n_fail++; $display("FAIL mask_req: got %b want 10", if1.flush_cache_req_o);
    end
    ack = 2'b01;
    tick(); ack = 2'b00; #1;
    n_checks++;
    if (if1.flush_cache_req_o !== 2'b10 || if1.busy_o !== 1'b1) begin
      n_fail++; $display("FAIL mask_ack0_ignored: req=%b busy=%b want 10 1", if1.flush_cache_req_o, if1.busy_o);
    end
    ack = 2'b11;
    tick(); ack = 2'b00; #1;
    n_checks++;
    if (act1 !== exp_vec(1) || if1.busy_o !== 1'b0 || act0 !== exp_vec(0)) begin
      n_fail++; $display("FAIL mask_both_ack: dut1=%h want %h dut0=%h want %h",
                         act1, exp_vec(1), act0, exp_vec(0));
    end
  endtask

  task automatic test_timeout();
    clr_in(); fen = 1'b1;
    tick(); fen = 1'b0;
    tick(7); #1;
    n_checks++;
    if (if0.busy_o !== 1'b1 || if0.flush_timeout_o !== 1'b0) begin
      n_fail++; $display("FAIL wd_c8: busy=%b to=%b want 1 0", if0.busy_o, if0.flush_timeout_o);
    end
    tick(); #1;
    n_checks++;
    if (if0.busy_o !== 1'b0 || if0.flush_timeout_o !== 1'b1 || if0.flush_cache_req_o !== 2'b00 || if0.halt_o !== 1'b0) begin
      n_fail++; $display("FAIL wd_c9: busy=%b to=%b req=%b halt=%b want 0 1 00 0",
                         if0.busy_o, if0.flush_timeout_o, if0.flush_cache_req_o, if0.halt_o);
    end
    n_checks++;
    if (if1.flush_cache_req_o !== 2'b10 || if1.busy_o !== 1'b1) begin
      n_fail++; $display("FAIL nowd_still_busy: req=%b busy=%b want 10 1", if1.flush_cache_req_o, if1.busy_o);
    end
    fen = 1'b1; #1;
    n_checks++;
    if (if1.flush_if_o !== 1'b1 || if1.flush_ex_o !== 1'b1) begin
      n_fail++; $display("FAIL fence_while_busy_comb: if=%b ex=%b want 1 1", if1.flush_if_o, if1.flush_ex_o);
    end
    tick(); fen = 1'b0; #1;
    n_checks++;
    if (if0.flush_timeout_o !== 1'b0 || if0.busy_o !== 1'b1 || if0.flush_cache_req_o !== 2'b11) begin
      n_fail++; $display("FAIL wd_rearm: to=%b busy=%b req=%b want 0 1 11",
                         if0.flush_timeout_o, if0.busy_o, if0.flush_cache_req_o);
    end
    ack = 2'b11;
    tick(); ack = 2'b00;
  endtask

  task automatic test_ack_at_timeout();
    clr_in(); fen = 1'b1;
    tick(); fen = 1'b0;
    tick(2); ack = 2'b01;
    tick(); ack = 2'b00;
    tick(4); ack = 2'b10;
    tick(); ack = 2'b00; #1;
    n_checks++;
    if (if0.busy_o !== 1'b0 || if0.flush_timeout_o !== 1'b0 || if0.flush_cache_req_o !== 2'b00) begin
      n_fail++; $display("FAIL ack_wins: busy=%b to=%b req=%b want 0 0 00",
                         if0.busy_o, if0.flush_timeout_o, if0.flush_cache_req_o);
    end
  endtask

  task automatic test_priority();
    clr_in(); exv = 1'b1; cmt = 1'b1; #1;
    n_checks++;
    if (if0.set_pc_commit_o !== 1'b0 || if0.flush_bp_o !== 1'b1 || if0.flush_id_o !== 1'b1) begin
      n_fail++; $display("FAIL trap_over_commit: pc=%b bp=%b id=%b want 0 1 1",
                         if0.set_pc_commit_o, if0.flush_bp_o, if0.flush_id_o);
    end
    clr_in(); mis = 1'b1; #1;
    n_checks++;
    if (if0.flush_id_o !== 1'b0 || if0.flush_if_o !== 1'b1 || if0.flush_unissued_instr_o !== 1'b1 || if0.set_pc_commit_o !== 1'b0) begin
      n_fail++; $display("FAIL mispredict_only: id=%b if=%b un=%b pc=%b want 0 1 1 0",
                         if0.flush_id_o, if0.flush_if_o, if0.flush_unissued_instr_o, if0.set_pc_commit_o);
    end
    clr_in(); sfv = 1'b1; #1;
    n_checks++;
    if (if0.flush_tlb_o !== 1'b1 || if0.set_pc_commit_o !== 1'b1 || if0.flush_icache_o !== 1'b0) begin
      n_fail++; $display("FAIL sfence: tlb=%b pc=%b ic=%b want 1 1 0",
                         if0.flush_tlb_o, if0.set_pc_commit_o, if0.flush_icache_o);
    end
    clr_in();
    tick();
  endtask

  task automatic test_async_reset();
    clr_in(); fen = 1'b1;
    tick(); fen = 1'b0;
    tick(); #1;
    n_checks++;
    if (if0.flush_cache_req_o !== 2'b11) begin
      n_fail++; $display("FAIL arst_pre: req=%b want 11", if0.flush_cache_req_o);
    end
    rst_ni = 1'b0; #1;
    model_reset();
    n_checks++;
    if (act0 !== 13'h0 || act1 !== 13'h0) begin
      n_fail++; $display("FAIL arst_immediate: dut0=%h dut1=%h want 0000 0000", act0, act1);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    ack = 2'b11;
    tick(); ack = 2'b00; #1;
    n_checks++;
    if (act0 !== 13'h0 || act1 !== 13'h0) begin
      n_fail++; $display("FAIL arst_stale_ack: dut0=%h dut1=%h want 0000 0000", act0, act1);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      mis = ($urandom_range(3) == 0);
      fen = ($urandom_range(9) == 0);
      fii = ($urandom_range(11) == 0);
      sfv = ($urandom_range(9) == 0);
      csr = ($urandom_range(9) == 0);
      cmt = ($urandom_range(9) == 0);
      exv = ($urandom_range(11) == 0);
      ert = ($urandom_range(15) == 0);
      dbg = ($urandom_range(15) == 0);
      hlt = ($urandom_range(7) == 0);
      ack = {($urandom_range(5) == 0), ($urandom_range(5) == 0)};
      #1;
      n_checks++;
      if (act0 !== exp_vec(0)) begin
        n_fail++; $display("FAIL rand_dut0 cyc %0d: got %h want %h", c, act0, exp_vec(0));
      end
      n_checks++;
      if (act1 !== exp_vec(1)) begin
        n_fail++; $display("FAIL rand_dut1 cyc %0d: got %h want %h", c, act1, exp_vec(1));
      end
      tick();
    end
    clr_in();
  endtask

  initial begin
    test_reset();
    test_fence_seq();
    test_partial_mask();
    test_timeout();
    test_ack_at_timeout();
    test_priority();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
